// File: rtl/lap_stopwatch.sv
// Stopwatch with start/stop, lap hold and clear, driving a multiplexed active-low 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits from d2 upward.
module lap_stopwatch #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int SCAN_HZ    = 400,
    parameter int NUM_DIGITS = 8
) (
    input  logic                  cp,
    input  logic                  reset,
    input  logic                  start_stop,
    input  logic                  lap_clr,
    output logic [NUM_DIGITS-1:0] LED_bit,
    output logic [7:0]            LED_SEG,
    output logic                  running,
    output logic                  ovf
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE} state_t;

    state_t                      state_q, state_d;
    logic                        ss_q, ss_d, lc_q, lc_d;
    logic [TW-1:0]               presc_q, presc_d;
    logic [SW-1:0]               scan_q, scan_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]  digit_q, digit_d;
    logic [NUM_DIGITS-1:0][3:0]  lap_q, lap_d;
    logic                        ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0]       led_bit_q, led_bit_d;
    logic [7:0]                  led_seg_q, led_seg_d;

    logic                        ss_evt, lc_evt, counting, tick, carry, dp;
    logic [NUM_DIGITS-1:0][3:0]  shown;
    logic [3:0]                  cur;
    logic [6:0]                  seg;
`ifdef LEADING_ZERO_BLANK_EN
    logic                        hi_zero;
`endif

    function automatic logic [3:0] digit_max(input int i);
        return (i == 3 || i == 5) ? 4'd5 : 4'd9;
    endfunction

    // Segment order {g,f,e,d,c,b,a}, active-high here; codes above 9 blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        ss_d    = start_stop;
        lc_d    = lap_clr;
        presc_d = presc_q;
        scan_d  = scan_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;

        ss_evt   = start_stop & ~ss_q;
        lc_evt   = lap_clr & ~lc_q;
        counting = (state_q == S_RUN) || (state_q == S_LAP);
        tick     = counting && (presc_q == TICK_LAST);

        if (state_q == S_IDLE)
            presc_d = '0;
        else if (counting)
            presc_d = tick ? '0 : presc_q + 1'b1;

        // carry means "tick and every lower digit is at its maximum"
        carry = tick;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry)
                digit_d[i] = (digit_q[i] == digit_max(i)) ? 4'd0 : digit_q[i] + 4'd1;
            carry = carry && (digit_q[i] == digit_max(i));
        end
        if (carry)
            ovf_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (ss_evt) state_d = S_RUN;
            end
            S_RUN: begin
                if (ss_evt) begin
                    state_d = S_PAUSE;
                end else if (lc_evt) begin
                    state_d = S_LAP;
                    lap_d   = digit_q;
                end
            end
            S_LAP: begin
                if (ss_evt)      state_d = S_PAUSE;
                else if (lc_evt) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (ss_evt) begin
                    state_d = S_RUN;
                end else if (lc_evt) begin
                    state_d = S_IDLE;
                    digit_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            scan_d = scan_q + 1'b1;
        end

        shown = (state_q == S_LAP) ? lap_q : digit_q;
        cur   = shown[idx_q];
        dp    = (int'(idx_q) == 2) || (int'(idx_q) == 4) || (int'(idx_q) == 6);
        seg   = seg7(cur);
`ifdef LEADING_ZERO_BLANK_EN
        hi_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (i >= int'(idx_q) && shown[i] != 4'd0) hi_zero = 1'b0;
        if (hi_zero && int'(idx_q) >= 2)
            seg = 7'h00;
`endif
        led_seg_d = ~{dp, seg};
        led_bit_d = ~(ONE_HOT0 << idx_q);
    end

    always_ff @(posedge cp) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ss_q      <= 1'b0;
            lc_q      <= 1'b0;
            presc_q   <= '0;
            scan_q    <= '0;
            idx_q     <= '0;
            digit_q   <= '0;
            lap_q     <= '0;
            ovf_q     <= 1'b0;
            led_bit_q <= '1;
            led_seg_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            ss_q      <= ss_d;
            lc_q      <= lc_d;
            presc_q   <= presc_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            digit_q   <= digit_d;
            lap_q     <= lap_d;
            ovf_q     <= ovf_d;
            led_bit_q <= led_bit_d;
            led_seg_q <= led_seg_d;
        end
    end

    assign LED_bit = led_bit_q;
    assign LED_SEG = led_seg_q;
    assign running = (state_q == S_RUN) || (state_q == S_LAP);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench: slow DUT (tick every 10 cp) for FSM/lap checks, two fast DUTs (tick every 2 cp) for carry/overflow.
module tb_lap_stopwatch;

    logic cp = 1'b0;
    always #5 cp = ~cp;

    logic       reset = 1'b1, start_stop = 1'b0, lap_clr = 1'b0;
    logic       reset2 = 1'b1, ss2 = 1'b0, lc2 = 1'b0;
    logic [7:0] led_bit, led_seg, f_bit, f_seg, q_seg;
    logic [3:0] q_bit;
    logic       running, ovf, f_run, f_ovf, q_run, q_ovf;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    always @(posedge cp) cyc <= cyc + 1;

    lap_stopwatch #(.CLK_HZ(40), .TICK_HZ(4), .SCAN_HZ(20), .NUM_DIGITS(8)) dut (
        .cp(cp), .reset(reset), .start_stop(start_stop), .lap_clr(lap_clr),
        .LED_bit(led_bit), .LED_SEG(led_seg), .running(running), .ovf(ovf));

    lap_stopwatch #(.CLK_HZ(40), .TICK_HZ(20), .SCAN_HZ(20), .NUM_DIGITS(8)) dut_f (
        .cp(cp), .reset(reset2), .start_stop(ss2), .lap_clr(lc2),
        .LED_bit(f_bit), .LED_SEG(f_seg), .running(f_run), .ovf(f_ovf));

    lap_stopwatch #(.CLK_HZ(40), .TICK_HZ(20), .SCAN_HZ(20), .NUM_DIGITS(4)) dut_q (
        .cp(cp), .reset(reset2), .start_stop(ss2), .lap_clr(lc2),
        .LED_bit(q_bit), .LED_SEG(q_seg), .running(q_run), .ovf(q_ovf));

    function automatic logic [7:0] exp_seg(input int d, input int k);
        logic [6:0] s;
        case (d)
            0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66;
            5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; 9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        return ~{(k == 2 || k == 4 || k == 6), s};
    endfunction

    // Leaves the bench 1 time unit after edge e.
    task automatic wait_to(input int e);
        while (cyc < e) begin
            @(posedge cp);
            #1;
        end
    endtask

    // which: 0 start, 1 lap, 2 both (slow DUT); 3 start, 4 lap (fast DUTs). Input is sampled at edge e.
    task automatic pulse(input int which, input int e);
        wait_to(e - 1);
        case (which)
            0: start_stop = 1'b1;
            1: lap_clr = 1'b1;
            2: begin start_stop = 1'b1; lap_clr = 1'b1; end
            3: ss2 = 1'b1;
            default: lc2 = 1'b1;
        endcase
        @(posedge cp);
        #1;
        start_stop = 1'b0; lap_clr = 1'b0; ss2 = 1'b0; lc2 = 1'b0;
    endtask

    // which: 0 slow DUT, 1 fast 8-digit, 2 fast 4-digit. Returns X if the digit never shows.
    task automatic read_seg(input int which, input int k, output logic [7:0] seg);
        logic [7:0] sel8;
        logic [3:0] sel4;
        sel8 = 8'd1 << k;
        sel4 = 4'd1 << k;
        seg  = 'x;
        for (int n = 0; n < 40; n++) begin
            @(negedge cp);
            if (which == 0 && led_bit == ~sel8) begin seg = led_seg; break; end
            if (which == 1 && f_bit == ~sel8)   begin seg = f_seg;   break; end
            if (which == 2 && q_bit == ~sel4)   begin seg = q_seg;   break; end
        end
    endtask

    task automatic test_reset;
        logic [7:0] s;
        int a;
        repeat (3) @(posedge cp);
        #1;
        tests++; if (led_bit !== 8'hFF) begin fails++; $display("FAIL rst_led_bit: got %h want ff", led_bit); end
        tests++; if (led_seg !== 8'hFF) begin fails++; $display("FAIL rst_led_seg: got %h want ff", led_seg); end
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL rst_running: got %b want 0", running); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        reset = 1'b0; reset2 = 1'b0;
        a = cyc + 2;
        pulse(0, a);
        wait_to(a + 374);
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL pre_rst_running: got %b want 1", running); end
        reset = 1'b1;
        @(posedge cp);
        #1;
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL midrst_running: got %b want 0", running); end
        tests++; if (led_seg !== 8'hFF) begin fails++; $display("FAIL midrst_seg: got %h want ff", led_seg); end
        tests++; if (led_bit !== 8'hFF) begin fails++; $display("FAIL midrst_bit: got %h want ff", led_bit); end
        reset = 1'b0;
        read_seg(0, 0, s);
        tests++; if (s !== exp_seg(0, 0)) begin fails++; $display("FAIL midrst_d0: got %h want %h", s, exp_seg(0, 0)); end
        read_seg(0, 1, s);
        tests++; if (s !== exp_seg(0, 1)) begin fails++; $display("FAIL midrst_d1: got %h want %h", s, exp_seg(0, 1)); end
    endtask

    task automatic test_count;
        logic [7:0] s;
        int a;
        int want [4] = '{3, 2, 1, 0};
        a = cyc + 2;
        pulse(0, a);
        wait_to(a + 100);
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL cnt_running: got %b want 1", running); end
        pulse(0, a + 1235);
        for (int k = 0; k < 4; k++) begin
            read_seg(0, k, s);
            tests++; if (s !== exp_seg(want[k], k)) begin fails++; $display("FAIL cnt_d%0d: got %h want %h", k, s, exp_seg(want[k], k)); end
        end
        pulse(1, cyc + 2);
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL clr_running: got %b want 0", running); end
        read_seg(0, 2, s);
        tests++; if (s !== exp_seg(0, 2)) begin fails++; $display("FAIL clr_d2: got %h want %h", s, exp_seg(0, 2)); end
    endtask

    task automatic test_lap;
        logic [7:0] s;
        int a;
        a = cyc + 2;
        pulse(0, a);
        pulse(1, a + 55);
        read_seg(0, 0, s);
        tests++; if (s !== exp_seg(5, 0)) begin fails++; $display("FAIL lap_d0: got %h want %h", s, exp_seg(5, 0)); end
        read_seg(0, 1, s);
        tests++; if (s !== exp_seg(0, 1)) begin fails++; $display("FAIL lap_d1: got %h want %h", s, exp_seg(0, 1)); end
        pulse(1, a + 255);
        pulse(1, a + 257);
        read_seg(0, 0, s);
        tests++; if (s !== exp_seg(5, 0)) begin fails++; $display("FAIL lap2_d0: got %h want %h", s, exp_seg(5, 0)); end
        read_seg(0, 1, s);
        tests++; if (s !== exp_seg(2, 1)) begin fails++; $display("FAIL lap2_d1: got %h want %h", s, exp_seg(2, 1)); end
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL lap_running: got %b want 1", running); end
        pulse(0, a + 305);
        read_seg(0, 0, s);
        tests++; if (s !== exp_seg(0, 0)) begin fails++; $display("FAIL live_d0: got %h want %h", s, exp_seg(0, 0)); end
        read_seg(0, 1, s);
        tests++; if (s !== exp_seg(3, 1)) begin fails++; $display("FAIL live_d1: got %h want %h", s, exp_seg(3, 1)); end
        pulse(1, cyc + 2);
    endtask

    task automatic test_same_cycle;
        logic [7:0] s;
        int a;
        a = cyc + 2;
        pulse(0, a);
        pulse(2, a + 73);
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL both_running: got %b want 0", running); end
        repeat (30) @(posedge cp);
        read_seg(0, 0, s);
        tests++; if (s !== exp_seg(7, 0)) begin fails++; $display("FAIL both_held_d0: got %h want %h", s, exp_seg(7, 0)); end
        pulse(1, cyc + 2);
        read_seg(0, 0, s);
        tests++; if (s !== exp_seg(0, 0)) begin fails++; $display("FAIL both_clr_d0: got %h want %h", s, exp_seg(0, 0)); end
        pulse(1, cyc + 2);
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL idle_lap_running: got %b want 0", running); end
    endtask

    task automatic test_overflow;
        logic [7:0] s;
        int b;
        int want_f [8] = '{9, 9, 9, 5, 0, 0, 0, 0};
        int want_c [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        b = cyc + 2;
        pulse(3, b);
        pulse(3, b + 11999);
        for (int k = 0; k < 8; k++) begin
            read_seg(1, k, s);
            tests++; if (s !== exp_seg(want_f[k], k)) begin fails++; $display("FAIL pre_f_d%0d: got %h want %h", k, s, exp_seg(want_f[k], k)); end
        end
        read_seg(2, 3, s);
        tests++; if (s !== exp_seg(5, 3)) begin fails++; $display("FAIL pre_q_d3: got %h want %h", s, exp_seg(5, 3)); end
        tests++; if (q_ovf !== 1'b0) begin fails++; $display("FAIL pre_q_ovf: got %b want 0", q_ovf); end
        b = cyc + 2;
        pulse(3, b);
        pulse(3, b + 2);
        for (int k = 0; k < 8; k++) begin
            read_seg(1, k, s);
            tests++; if (s !== exp_seg(want_c[k], k)) begin fails++; $display("FAIL carry_f_d%0d: got %h want %h", k, s, exp_seg(want_c[k], k)); end
        end
        for (int k = 0; k < 4; k++) begin
            read_seg(2, k, s);
            tests++; if (s !== exp_seg(0, k)) begin fails++; $display("FAIL wrap_q_d%0d: got %h want %h", k, s, exp_seg(0, k)); end
        end
        tests++; if (q_ovf !== 1'b1) begin fails++; $display("FAIL wrap_q_ovf: got %b want 1", q_ovf); end
        tests++; if (f_ovf !== 1'b0) begin fails++; $display("FAIL wrap_f_ovf: got %b want 0", f_ovf); end
        b = cyc + 2;
        pulse(3, b);
        pulse(3, b + 21);
        tests++; if (q_ovf !== 1'b1) begin fails++; $display("FAIL sticky_q_ovf: got %b want 1", q_ovf); end
        pulse(4, cyc + 2);
        tests++; if (q_ovf !== 1'b0) begin fails++; $display("FAIL clr_q_ovf: got %b want 0", q_ovf); end
        read_seg(2, 0, s);
        tests++; if (s !== exp_seg(0, 0)) begin fails++; $display("FAIL clr_q_d0: got %h want %h", s, exp_seg(0, 0)); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_count;
        test_lap;
        test_same_cycle;
        test_overflow;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
